// File: rtl/paint_frame_buffer_if.sv
// Brush/cursor and VGA read-side signals of the paint canvas frame buffer.
// The master is the brush/pixel logic; the slave is the frame buffer itself.
interface paint_frame_buffer_if #(
   parameter int COLOUR_W = 12
);
   logic                write_valid;
   logic                write_ready;
   logic [9:0]          write_x;
   logic [9:0]          write_y;
   logic [1:0]          brush_sel;
   logic [COLOUR_W-1:0] write_colour;
   logic                clear_req;
   logic [COLOUR_W-1:0] clear_colour;
   logic                busy;
   logic [9:0]          read_x;
   logic [9:0]          read_y;
   logic [COLOUR_W-1:0] read_colour;

   modport master (
      output write_valid, write_x, write_y, brush_sel, write_colour,
      output clear_req, clear_colour, read_x, read_y,
      input  write_ready, busy, read_colour
   );

   modport slave (
      input  write_valid, write_x, write_y, brush_sel, write_colour,
      input  clear_req, clear_colour, read_x, read_y,
      output write_ready, busy, read_colour
   );
endinterface

// File: rtl/paint_frame_buffer.sv
// Downscaled paint canvas: square-brush stamp engine, clear-to-colour sweep
// and a registered read-first read port feeding the VGA pipeline.
module paint_frame_buffer #(
   parameter int                  SCREEN_W    = 640,
   parameter int                  SCREEN_H    = 480,
   parameter int                  SCALE_SHIFT = 3,
   parameter int                  COLOUR_W    = 12,
   parameter logic [COLOUR_W-1:0] INIT_COLOUR = 12'hFFF,
   parameter logic [COLOUR_W-1:0] OOB_COLOUR  = 12'h000
) (
   input logic                  clk,
   input logic                  reset,
   paint_frame_buffer_if.slave  bus
);
   localparam int MEM_W  = SCREEN_W >> SCALE_SHIFT;
   localparam int MEM_H  = SCREEN_H >> SCALE_SHIFT;
   localparam int DEPTH  = MEM_W * MEM_H;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CW     = 10 - SCALE_SHIFT;
   localparam int SW     = CW + 1;

   typedef enum logic [1:0] {CLEAR, IDLE, STAMP} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   counter;
   logic [COLOUR_W-1:0] fill;
   logic [COLOUR_W-1:0] stamp_colour;
   logic [CW-1:0]       cx, cy;
   logic [1:0]          sel;
   logic [2:0]          dx, dy;
   logic [2:0]          side_m1;
   logic                busy_r, ready_r;
   logic [SW-1:0]       sx, sy;
   logic                stamp_in;
   logic                accept;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [COLOUR_W-1:0] wr_data;
   logic [9:0]          rcx, rcy;
   logic                rd_oob;
   logic [ADDR_W-1:0]   raddr;
   logic [COLOUR_W-1:0] rd_colour_p1;
   logic [COLOUR_W-1:0] mem [DEPTH];

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [ADDR_W-1:0] col,
                                                   input logic [ADDR_W-1:0] row);
      return row * ADDR_W'(MEM_W) + col;
   endfunction

   assign side_m1  = 3'((4'd1 << sel) - 4'd1);
   // One extra bit so origin+offset never wraps back onto the canvas
   assign sx       = SW'(cx) + SW'(dx);
   assign sy       = SW'(cy) + SW'(dy);
   assign stamp_in = (sx < SW'(MEM_W)) && (sy < SW'(MEM_H));
   assign accept   = (state == IDLE) && bus.write_valid && !bus.clear_req;

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = counter;
      wr_data = fill;
      if (state == CLEAR) begin
         wr_en = 1'b1;
      end else if (state == STAMP) begin
         wr_en   = stamp_in && !bus.clear_req;
         wr_addr = cell_addr(ADDR_W'(sx), ADDR_W'(sy));
         wr_data = stamp_colour;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= CLEAR;
         fill    <= INIT_COLOUR;
         counter <= '0;
         dx      <= '0;
         dy      <= '0;
         busy_r  <= 1'b1;
         ready_r <= 1'b0;
      end else if (bus.clear_req) begin
         state   <= CLEAR;
         fill    <= bus.clear_colour;
         counter <= '0;
         busy_r  <= 1'b1;
         ready_r <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               if (counter == ADDR_W'(DEPTH - 1)) begin
                  state   <= IDLE;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end else begin
                  counter <= counter + ADDR_W'(1);
               end
            end
            IDLE: begin
               if (bus.write_valid) begin
                  state   <= STAMP;
                  dx      <= '0;
                  dy      <= '0;
                  busy_r  <= 1'b1;
                  ready_r <= 1'b0;
               end
            end
            STAMP: begin
               if (dx == side_m1) begin
                  dx <= '0;
                  if (dy == side_m1) begin
                     state   <= IDLE;
                     busy_r  <= 1'b0;
                     ready_r <= 1'b1;
                  end else begin
                     dy <= dy + 3'd1;
                  end
               end else begin
                  dx <= dx + 3'd1;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

   // Stamp parameters are plain data captured on acceptance
   always_ff @(posedge clk) begin
      if (accept) begin
         cx           <= CW'(bus.write_x >> SCALE_SHIFT);
         cy           <= CW'(bus.write_y >> SCALE_SHIFT);
         sel          <= bus.brush_sel;
         stamp_colour <= bus.write_colour;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rcx    = bus.read_x >> SCALE_SHIFT;
   assign rcy    = bus.read_y >> SCALE_SHIFT;
   assign rd_oob = (rcx >= 10'(MEM_W)) || (rcy >= 10'(MEM_H));
   assign raddr  = rd_oob ? '0 : cell_addr(ADDR_W'(rcx), ADDR_W'(rcy));

   // ---- read stage p1: samples mem before this edge's write lands ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                rd_colour_p1 <= INIT_COLOUR;
      else if (rd_oob)          rd_colour_p1 <= OOB_COLOUR;
      else if (state == CLEAR)  rd_colour_p1 <= fill;
      else                      rd_colour_p1 <= mem[raddr];
   end

   assign bus.read_colour = rd_colour_p1;
   assign bus.busy        = busy_r;
   assign bus.write_ready = ready_r;
endmodule

// File: tb/tb_paint_frame_buffer.sv
// Randomised scenario bench for paint_frame_buffer against a canvas array model.
module tb_paint_frame_buffer;
   logic clk;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [11:0] model [4800];

   paint_frame_buffer_if #(.COLOUR_W(12)) fb ();

   paint_frame_buffer #(
      .SCREEN_W(640), .SCREEN_H(480), .SCALE_SHIFT(3), .COLOUR_W(12),
      .INIT_COLOUR(12'hFFF), .OOB_COLOUR(12'h000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (fb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_fill(input logic [11:0] c);
      for (int i = 0; i < 4800; i++) model[i] = c;
   endtask

   task automatic model_stamp(input int x, input int y, input int sel, input logic [11:0] c);
      int side;
      side = 1 << sel;
      for (int dy = 0; dy < side; dy++)
         for (int dx = 0; dx < side; dx++)
            if ((x >> 3) + dx < 80 && (y >> 3) + dy < 60)
               model[((y >> 3) + dy) * 80 + (x >> 3) + dx] = c;
   endtask

   function automatic logic [11:0] expect_read(input int x, input int y);
      if ((x >> 3) >= 80 || (y >> 3) >= 60) return 12'h000;
      return model[(y >> 3) * 80 + (x >> 3)];
   endfunction

   task automatic count_busy(inout int n);
      while (fb.busy === 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic do_stamp(input int x, input int y, input int sel, input logic [11:0] c,
                           output int cycles);
      fb.write_x = 10'(x);
      fb.write_y = 10'(y);
      fb.brush_sel = 2'(sel);
      fb.write_colour = c;
      fb.write_valid = 1'b1;
      @(negedge clk);
      fb.write_valid = 1'b0;
      cycles = 0;
      count_busy(cycles);
      model_stamp(x, y, sel, c);
   endtask

   task automatic scan_canvas(output int bad, output int fx, output int fy,
                              output logic [11:0] fgot, output logic [11:0] fexp);
      bad = 0; fx = 0; fy = 0; fgot = '0; fexp = '0;
      for (int cy = 0; cy < 60; cy++) begin
         for (int cx = 0; cx < 80; cx++) begin
            int x, y;
            logic [11:0] e;
            x = cx * 8 + int'($urandom_range(0, 7));
            y = cy * 8 + int'($urandom_range(0, 7));
            fb.read_x = 10'(x);
            fb.read_y = 10'(y);
            @(negedge clk);
            e = expect_read(x, y);
            if (fb.read_colour !== e) begin
               if (bad == 0) begin fx = cx; fy = cy; fgot = fb.read_colour; fexp = e; end
               bad++;
            end
         end
      end
   endtask

   task automatic test_reset();
      int n;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (fb.busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", fb.busy); end
      n_cmp++; if (fb.write_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", fb.write_ready); end
      n_cmp++; if (fb.read_colour !== 12'hFFF) begin n_bad++; $display("FAIL reset_read: got %h want fff", fb.read_colour); end
      fb.read_x = 10'd0;
      fb.read_y = 10'd0;
      reset = 1'b0;
      repeat (50) @(negedge clk);
      n_cmp++; if (fb.read_colour !== 12'hFFF) begin n_bad++; $display("FAIL read_during_init_clear: got %h want fff", fb.read_colour); end
      n = 50;
      count_busy(n);
      n_cmp++; if (n != 4800) begin n_bad++; $display("FAIL init_clear_cycles: got %0d want 4800", n); end
      n_cmp++; if (fb.write_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_clear: got %b want 1", fb.write_ready); end
      model_fill(12'hFFF);
      @(negedge clk);
      n_cmp++; if (fb.read_colour !== expect_read(0, 0)) begin n_bad++; $display("FAIL read_after_init: got %h want %h", fb.read_colour, expect_read(0, 0)); end
   endtask

   task automatic test_stamp_single();
      int n;
      do_stamp(16, 8, 0, 12'h0F0, n);
      n_cmp++; if (n != 1) begin n_bad++; $display("FAIL single_stamp_cycles: got %0d want 1", n); end
      fb.read_x = 10'd23; fb.read_y = 10'd15;
      @(negedge clk);
      n_cmp++; if (fb.read_colour !== expect_read(23, 15)) begin n_bad++; $display("FAIL single_stamp_hit: got %h want %h", fb.read_colour, expect_read(23, 15)); end
      fb.read_x = 10'd24; fb.read_y = 10'd8;
      @(negedge clk);
      n_cmp++; if (fb.read_colour !== expect_read(24, 8)) begin n_bad++; $display("FAIL single_stamp_neighbour: got %h want %h", fb.read_colour, expect_read(24, 8)); end
   endtask

   task automatic test_stamp_corner();
      int n;
      logic [11:0] c;
      c = 12'(($urandom_range(1, 4094)));
      do_stamp(624, 464, 2, c, n);
      n_cmp++; if (n != 16) begin n_bad++; $display("FAIL corner_stamp_cycles: got %0d want 16", n); end
      for (int dy = 0; dy < 4; dy++) begin
         for (int dx = 0; dx < 4; dx++) begin
            fb.read_x = 10'(624 + 8 * dx);
            fb.read_y = 10'(464 + 8 * dy);
            @(negedge clk);
            n_cmp++;
            if (fb.read_colour !== expect_read(624 + 8 * dx, 464 + 8 * dy)) begin
               n_bad++;
               $display("FAIL corner_cell(%0d,%0d): got %h want %h", 78 + dx, 58 + dy, fb.read_colour, expect_read(624 + 8 * dx, 464 + 8 * dy));
            end
         end
      end
      fb.read_x = 10'd640; fb.read_y = 10'd0;
      @(negedge clk);
      n_cmp++; if (fb.read_colour !== 12'h000) begin n_bad++; $display("FAIL oob_x640: got %h want 000", fb.read_colour); end
      fb.read_x = 10'd0; fb.read_y = 10'd480;
      @(negedge clk);
      n_cmp++; if (fb.read_colour !== 12'h000) begin n_bad++; $display("FAIL oob_y480: got %h want 000", fb.read_colour); end
   endtask

   task automatic test_read_first();
      logic [11:0] old_c, new_c;
      old_c = expect_read(80, 80);
      new_c = ~old_c;
      fb.write_x = 10'd80; fb.write_y = 10'd80; fb.brush_sel = 2'd0;
      fb.write_colour = new_c; fb.write_valid = 1'b1;
      fb.read_x = 10'd80; fb.read_y = 10'd80;
      @(negedge clk);
      fb.write_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (fb.read_colour !== old_c) begin n_bad++; $display("FAIL read_first_old: got %h want %h", fb.read_colour, old_c); end
      model_stamp(80, 80, 0, new_c);
      @(negedge clk);
      n_cmp++; if (fb.read_colour !== new_c) begin n_bad++; $display("FAIL read_first_new: got %h want %h", fb.read_colour, new_c); end
   endtask

   task automatic test_clear_abort();
      int n, bad, fx, fy;
      logic [11:0] fgot, fexp;
      fb.write_x = 10'(8 * $urandom_range(0, 70)); fb.write_y = 10'(8 * $urandom_range(0, 50));
      fb.brush_sel = 2'd3; fb.write_colour = 12'h0F0; fb.write_valid = 1'b1;
      @(negedge clk);
      fb.write_valid = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++; if (fb.busy !== 1'b1) begin n_bad++; $display("FAIL abort_stamp_running: got %b want 1", fb.busy); end
      fb.clear_colour = 12'h00F; fb.clear_req = 1'b1;
      @(negedge clk);
      fb.clear_req = 1'b0;
      n = 0;
      count_busy(n);
      n_cmp++; if (n != 4800) begin n_bad++; $display("FAIL abort_clear_cycles: got %0d want 4800", n); end
      model_fill(12'h00F);
      scan_canvas(bad, fx, fy, fgot, fexp);
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL abort_clear_scan: %0d bad cells, first (%0d,%0d) got %h want %h", bad, fx, fy, fgot, fexp); end
   endtask

   task automatic test_reset_mid_clear();
      int n, bad, fx, fy;
      logic [11:0] fgot, fexp;
      fb.clear_colour = 12'h5A5; fb.clear_req = 1'b1;
      @(negedge clk);
      fb.clear_req = 1'b0;
      repeat (100) @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++; if (fb.read_colour !== 12'hFFF) begin n_bad++; $display("FAIL midreset_read: got %h want fff", fb.read_colour); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      n = 0;
      count_busy(n);
      n_cmp++; if (n != 4800) begin n_bad++; $display("FAIL midreset_clear_cycles: got %0d want 4800", n); end
      model_fill(12'hFFF);
      scan_canvas(bad, fx, fy, fgot, fexp);
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL midreset_scan: %0d bad cells, first (%0d,%0d) got %h want %h", bad, fx, fy, fgot, fexp); end
   endtask

   task automatic test_clear_priority();
      int n, bad, fx, fy;
      logic [11:0] fgot, fexp;
      fb.write_x = 10'd200; fb.write_y = 10'd200; fb.brush_sel = 2'd3;
      fb.write_colour = 12'hF00; fb.write_valid = 1'b1;
      fb.clear_colour = 12'h3C3; fb.clear_req = 1'b1;
      @(negedge clk);
      fb.write_valid = 1'b0; fb.clear_req = 1'b0;
      n = 0;
      count_busy(n);
      n_cmp++; if (n != 4800) begin n_bad++; $display("FAIL priority_clear_cycles: got %0d want 4800", n); end
      repeat (3) @(negedge clk);
      n_cmp++; if (fb.busy !== 1'b0) begin n_bad++; $display("FAIL priority_no_late_stamp: busy got %b want 0", fb.busy); end
      model_fill(12'h3C3);
      scan_canvas(bad, fx, fy, fgot, fexp);
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL priority_scan: %0d bad cells, first (%0d,%0d) got %h want %h", bad, fx, fy, fgot, fexp); end
   endtask

   task automatic test_random_stamps();
      int n, sel, x, y, bad, fx, fy;
      logic [11:0] c, fgot, fexp;
      for (int k = 0; k < 30; k++) begin
         sel = int'($urandom_range(0, 3));
         x = int'($urandom_range(0, 1023));
         y = int'($urandom_range(0, 1023));
         if (k % 3 != 0) begin x = x % 640; y = y % 480; end
         c = 12'($urandom);
         do_stamp(x, y, sel, c, n);
         n_cmp++; if (n != (1 << (2 * sel))) begin n_bad++; $display("FAIL rand_stamp_cycles[%0d]: got %0d want %0d", k, n, 1 << (2 * sel)); end
         for (int r = 0; r < 3; r++) begin
            x = int'($urandom_range(0, 1023));
            y = int'($urandom_range(0, 1023));
            if (r != 0) begin x = x % 640; y = y % 480; end
            fb.read_x = 10'(x); fb.read_y = 10'(y);
            @(negedge clk);
            n_cmp++;
            if (fb.read_colour !== expect_read(x, y)) begin
               n_bad++;
               $display("FAIL rand_read(%0d,%0d): got %h want %h", x, y, fb.read_colour, expect_read(x, y));
            end
         end
      end
      scan_canvas(bad, fx, fy, fgot, fexp);
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rand_scan: %0d bad cells, first (%0d,%0d) got %h want %h", bad, fx, fy, fgot, fexp); end
   endtask

   initial begin
      reset = 1'b1;
      fb.write_valid = 1'b0; fb.write_x = '0; fb.write_y = '0; fb.brush_sel = '0;
      fb.write_colour = '0; fb.clear_req = 1'b0; fb.clear_colour = '0;
      fb.read_x = '0; fb.read_y = '0;
      test_reset();
      test_stamp_single();
      test_stamp_corner();
      test_read_first();
      test_random_stamps();
      test_clear_abort();
      test_reset_mid_clear();
      test_clear_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
